// File: rtl/check_node_minsum.sv
// Serial min-sum LDPC check-node: scans one row column-by-column, then writes all extrinsic lanes at once.
// Define OFFSET_MIN_SUM_EN to build the offset min-sum variant (saturating subtract of 1 on every output).
module check_node_minsum #(
    parameter int WIDTH_LLR = 5,
    parameter int MAX_COLS  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [MAX_COLS-1:0]               row_mask,
    input  logic [MAX_COLS*WIDTH_LLR-1:0]     llr_in,
    input  logic [MAX_COLS-1:0]               sign_in,
    output logic [MAX_COLS*(WIDTH_LLR+1)-1:0] llr_out,
    output logic [MAX_COLS-1:0]               sign_out,
    output logic                              busy,
    output logic                              done
);

    localparam int CNT_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam int OUT_W = WIDTH_LLR + 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(MAX_COLS - 1);

`ifdef OFFSET_MIN_SUM_EN
    localparam bit OFFSET_EN = 1'b1;
`else
    localparam bit OFFSET_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [CNT_W-1:0]              idx_q, idx_d;
    logic [WIDTH_LLR-1:0]          min1_q, min1_d;
    logic [WIDTH_LLR-1:0]          min2_q, min2_d;
    logic                          par_q, par_d;
    logic [MAX_COLS-1:0]           mask_q, mask_d;
    logic [MAX_COLS-1:0]           sign_q, sign_d;
    logic [WIDTH_LLR-1:0]          llr_q [MAX_COLS];
    logic [WIDTH_LLR-1:0]          llr_d [MAX_COLS];
    logic [MAX_COLS*OUT_W-1:0]     llr_out_q, llr_out_d;
    logic [MAX_COLS-1:0]           sign_out_q, sign_out_d;
    logic [WIDTH_LLR-1:0]          sel_mag;

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        min1_d     = min1_q;
        min2_d     = min2_q;
        par_d      = par_q;
        mask_d     = mask_q;
        sign_d     = sign_q;
        llr_d      = llr_q;
        llr_out_d  = llr_out_q;
        sign_out_d = sign_out_q;
        sel_mag    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d = row_mask;
                    sign_d = sign_in;
                    for (int i = 0; i < MAX_COLS; i++) begin
                        llr_d[i] = llr_in[i*WIDTH_LLR +: WIDTH_LLR];
                    end
                    min1_d  = '1;
                    min2_d  = '1;
                    idx_d   = '0;
                    par_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
                // Strict compares keep the first column as argmin on ties; the tied value drops into min2.
                if (mask_q[cnt_q]) begin
                    par_d = par_q ^ sign_q[cnt_q];
                    if (llr_q[cnt_q] < min1_q) begin
                        min2_d = min1_q;
                        min1_d = llr_q[cnt_q];
                        idx_d  = cnt_q;
                    end else if (llr_q[cnt_q] < min2_q) begin
                        min2_d = llr_q[cnt_q];
                    end
                end
                if (cnt_q == LAST_COL) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WRITE: begin
                for (int i = 0; i < MAX_COLS; i++) begin
                    if (mask_q[i]) begin
                        sel_mag = (idx_q == CNT_W'(i)) ? min2_q : min1_q;
                        if (OFFSET_EN && (sel_mag != '0)) begin
                            sel_mag = sel_mag - 1'b1;
                        end
                        llr_out_d[i*OUT_W +: OUT_W] = {1'b0, sel_mag};
                        sign_out_d[i]               = par_q ^ sign_q[i];
                    end else begin
                        llr_out_d[i*OUT_W +: OUT_W] = '0;
                        sign_out_d[i]               = 1'b0;
                    end
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the pre-edge value of every other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            min1_q     <= '0;
            min2_q     <= '0;
            par_q      <= 1'b0;
            mask_q     <= '0;
            sign_q     <= '0;
            // NOTE: the snapshot array is small register storage, not a RAM, so clearing it on reset is cheap and keeps X out.
            for (int i = 0; i < MAX_COLS; i++) begin
                llr_q[i] <= '0;
            end
            llr_out_q  <= '0;
            sign_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            min1_q     <= min1_d;
            min2_q     <= min2_d;
            par_q      <= par_d;
            mask_q     <= mask_d;
            sign_q     <= sign_d;
            llr_q      <= llr_d;
            llr_out_q  <= llr_out_d;
            sign_out_q <= sign_out_d;
        end
    end

    assign llr_out  = llr_out_q;
    assign sign_out = sign_out_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_check_node_minsum.sv
// Directed bench for check_node_minsum: a per-lane "min of the other columns" model feeds a scoreboard queue.
module tb_check_node_minsum;

    localparam int W     = 5;
    localparam int N     = 8;
    localparam int OUT_W = W + 1;

    typedef struct packed {
        logic [N*OUT_W-1:0] mag;
        logic [N-1:0]       sgn;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [N-1:0]       row_mask;
    logic [N*W-1:0]     llr_in;
    logic [N-1:0]       sign_in;
    logic [N*OUT_W-1:0] llr_out;
    logic [N-1:0]       sign_out;
    logic               busy;
    logic               done;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    check_node_minsum #(.WIDTH_LLR(W), .MAX_COLS(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .row_mask (row_mask),
        .llr_in   (llr_in),
        .sign_in  (sign_in),
        .llr_out  (llr_out),
        .sign_out (sign_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Extrinsic view: each unmasked lane gets the minimum magnitude and sign XOR of the *other* unmasked lanes.
    function automatic exp_t model(input logic [N-1:0] mask, input logic [N*W-1:0] mags,
                                   input logic [N-1:0] sgn);
        exp_t e;
        logic [W-1:0] m;
        logic         s;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                m = '1;
                s = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (j != i && mask[j]) begin
                        if (mags[j*W +: W] < m) m = mags[j*W +: W];
                        s = s ^ sgn[j];
                    end
                end
`ifdef OFFSET_MIN_SUM_EN
                if (m != '0) m = m - 1'b1;
`endif
                e.mag[i*OUT_W +: OUT_W] = {1'b0, m};
                e.sgn[i]                = s;
            end
        end
        return e;
    endfunction

    // mode 0: plain row; mode 1: re-start and input changes during SCAN; mode 2: reset at cnt=4.
    task automatic run_row(input string tag, input logic [N-1:0] mask, input logic [N*W-1:0] mags,
                           input logic [N-1:0] sgn, input int mode);
        exp_t e;
        int   lat;
        int   extra;
        lat = -1;
        @(negedge clk);
        row_mask = mask;
        llr_in   = mags;
        sign_in  = sgn;
        start    = 1'b1;
        if (mode != 2) sb.push_back(model(mask, mags, sgn));
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (mode == 1 && k == 3) begin
                start    = 1'b1;
                llr_in   = ~mags;
                sign_in  = ~sgn;
                row_mask = '1;
            end
            if (mode == 1 && k == 5) start = 1'b0;
            if (mode == 2 && k == 4) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, 64'(busy), 64'd0);
                check({tag, "_rst_done"}, 64'(done), 64'd0);
                check({tag, "_rst_llr"}, 64'(llr_out), 64'd0);
                check({tag, "_rst_sign"}, 64'(sign_out), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(N + 1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_llr"}, 64'(llr_out), 64'(e.mag));
            check({tag, "_sign"}, 64'(sign_out), 64'(e.sgn));
        end
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        if (mode == 1) begin
            extra = 0;
            for (int k = 0; k < 15; k++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            check({tag, "_no_extra_done"}, 64'(extra), 64'd0);
        end
    endtask

    logic [N*W-1:0] mags_s1;
    logic [N*W-1:0] mags_tie;
    logic [N*W-1:0] mags_one;
    logic [W-1:0]   exp_c3;
    logic [W-1:0]   exp_c0;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        row_mask = '0;
        llr_in   = '0;
        sign_in  = '0;
        mags_s1  = {5'd2, 5'd4, 5'd7, 5'd6, 5'd1, 5'd8, 5'd3, 5'd5};
        mags_tie = {5'd4, 5'd4, 5'd1, 5'd4, 5'd4, 5'd1, 5'd4, 5'd4};
        mags_one = {5'd3, 5'd3, 5'd3, 5'd7, 5'd3, 5'd3, 5'd3, 5'd3};
`ifdef OFFSET_MIN_SUM_EN
        exp_c3 = 5'd1;
        exp_c0 = 5'd0;
`else
        exp_c3 = 5'd2;
        exp_c0 = 5'd1;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_llr", 64'(llr_out), 64'd0);
        check("reset_sign", 64'(sign_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_row("s1", 8'hFF, mags_s1, 8'h09, 0);
        check("s1_c3_direct", 64'(llr_out[3*OUT_W +: OUT_W]), 64'(exp_c3));
        check("s1_c0_direct", 64'(llr_out[0 +: OUT_W]), 64'(exp_c0));
        check("s1_sign_direct", 64'(sign_out), 64'h09);

        run_row("tie", 8'hFF, mags_tie, 8'h01, 0);
        check("tie_sign_direct", 64'(sign_out), 64'hFE);

        run_row("single", 8'h10, mags_one, 8'hFF, 0);
`ifdef OFFSET_MIN_SUM_EN
        check("single_c4_direct", 64'(llr_out[4*OUT_W +: OUT_W]), 64'd30);
`else
        check("single_c4_direct", 64'(llr_out[4*OUT_W +: OUT_W]), 64'd31);
`endif

        run_row("empty", 8'h00, mags_s1, 8'hFF, 0);
        run_row("restart", 8'hFF, mags_s1, 8'h09, 1);
        run_row("partial", 8'h5A, mags_tie, 8'h33, 0);
        run_row("abort", 8'hFF, mags_s1, 8'h09, 2);
        run_row("s1_rerun", 8'hFF, mags_s1, 8'h09, 0);

        for (int r = 0; r < 4; r++) begin
            run_row($sformatf("rand%0d", r), N'($urandom), (N*W)'({$urandom, $urandom}),
                    N'($urandom), 0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
